uart_rx_frame_ctrl: RTL and testbench

Framing controller that sits directly behind the 8-bit UART receiver and sequences its byte stream into validated packets. It hunts for a start-of-frame byte, then captures a length byte, the payload and an XOR checksum. Each checked frame is buffered and released downstream over a valid/ready interface. Malformed, stalled or overrun frames are discarded and flagged with an error code.

---
 rtl/uart_rx_frame_ctrl.sv | 108 ++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frames a UART byte stream (SOF, LEN, payload, XOR csum) into checked packets
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_t;
  state_t state;
  logic [7:0] mem [MAX_LEN];
  logic [IW-1:0] wr_idx, rd_idx, lm1;
  logic [7:0] csum;
  logic [TW-1:0] tcnt;
  logic timed, tmo, xfer;
  assign timed = state inside {LEN, PAYLOAD, CSUM};
  assign tmo = timed && !rx_valid && tcnt == TW'(TIMEOUT - 1);
  assign xfer = out_valid && out_ready;
  assign out_valid = state == DRAIN;
  assign busy = state != IDLE;
  assign out_last = out_valid && rd_idx == lm1;
  assign out_data = out_valid ? mem[rd_idx] : '0;
  // lm1 holds L-1 so it fits the index width even when L == MAX_LEN
  always_ff @(posedge clk)
    if (state == PAYLOAD && rx_valid) mem[wr_idx] <= rx_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wr_idx <= '0;
      rd_idx <= '0;
      lm1 <= '0;
      csum <= '0;
      tcnt <= '0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= 2'd0;
    end else begin
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= 2'd0;
      tcnt <= (rx_valid || !timed) ? '0 : tcnt + TW'(1);
      if (tmo) begin
        frame_err <= 1'b1;
        err_code <= 2'd2;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (rx_valid && rx_data == SOF) state <= LEN;
          LEN:
            if (rx_valid) begin
              if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                frame_err <= 1'b1;
                err_code <= 2'd0;
                state <= IDLE;
              end else begin
                lm1 <= IW'(rx_data - 8'd1);
                csum <= rx_data;
                wr_idx <= '0;
                state <= PAYLOAD;
              end
            end
          PAYLOAD:
            if (rx_valid) begin
              csum <= csum ^ rx_data;
              wr_idx <= wr_idx + IW'(1);
              if (wr_idx == lm1) state <= CSUM;
            end
          CSUM:
            if (rx_valid) begin
              if (rx_data == csum) begin
                frame_ok <= 1'b1;
                rd_idx <= '0;
                state <= DRAIN;
              end else begin
                frame_err <= 1'b1;
                err_code <= 2'd1;
                state <= IDLE;
              end
            end
          DRAIN: begin
            if (rx_valid) begin
              frame_err <= 1'b1;
              err_code <= 2'd3;
            end
            if (xfer) begin
              rd_idx <= rd_idx + IW'(1);
              if (out_last) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames with a scoreboard of expected payload bytes and ok/err events
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic frame_ok;
  logic frame_err;
  logic [1:0] err_code;
  logic busy;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int s_cyc, err_cyc, ok_cyc, last_cyc;
  logic [8:0] outq[$];
  int evq[$];
  uart_rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected activity expected none", n);
  endtask
  // monitor: compares whatever the DUT presents against the scoreboard
  always @(negedge clk) begin
    int got;
    if (out_valid) begin
      if (outq.size() == 0) fail("out_unexp");
      else begin
        check("out", {out_last, out_data}, outq[0]);
        if (out_ready) begin
          void'(outq.pop_front());
          if (out_last) last_cyc = cyc;
        end
      end
    end
    if (frame_ok || frame_err) begin
      got = frame_ok ? -1 : int'(err_code);
      if (frame_err) err_cyc = cyc;
      if (frame_ok) begin
        ok_cyc = cyc;
        check("ok_latency", out_valid, 1);
      end
      if (evq.size() == 0) fail("event_unexp");
      else check("event", got, evq.pop_front());
    end
  end
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    s_cyc = cyc;
  endtask
  task automatic wait_drain(input int max);
    int n = 0;
    while ((outq.size() != 0 || evq.size() != 0) && n < max) begin
      @(posedge clk);
      n++;
    end
    if (outq.size() != 0 || evq.size() != 0) fail("drain_timeout");
    repeat (3) @(posedge clk);
    #1 check("idle", {busy, out_valid}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    out_ready = 1'b1;
    #3 check("reset_outs", {out_valid, out_data, out_last, frame_ok, frame_err, err_code, busy}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    // 1: good frame, full-rate drain
    evq.push_back(-1);
    outq.push_back({1'b0, 8'h11});
    outq.push_back({1'b0, 8'h22});
    outq.push_back({1'b1, 8'h33});
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    wait_drain(50);
    check("t1_consec", last_cyc - ok_cyc, 2);
    // 2: bad checksum
    evq.push_back(1);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    wait_drain(50);
    // 3: length limits, then junk ignored, then a good 1-byte frame
    evq.push_back(0);
    send(8'hA5); send(8'h11);
    evq.push_back(0);
    send(8'hA5); send(8'h00);
    send(8'h11); send(8'h22);
    evq.push_back(-1);
    outq.push_back({1'b1, 8'h5A});
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    wait_drain(50);
    // 4: timeout exactly TIMEOUT cycles after the last strobe
    evq.push_back(2);
    send(8'hA5); send(8'h02); send(8'h11);
    wait_drain(1200);
    check("tmo_cycles", err_cyc - s_cyc, 1024);
    // 4b: byte lands on the limit cycle and wins
    send(8'hA5); send(8'h02); send(8'h11);
    repeat (1022) @(posedge clk);
    evq.push_back(-1);
    outq.push_back({1'b0, 8'h11});
    outq.push_back({1'b1, 8'h22});
    send(8'h22); send(8'h31);
    wait_drain(50);
    // 5: backpressure with an overrun byte during drain
    #1 out_ready = 1'b0;
    evq.push_back(-1);
    outq.push_back({1'b0, 8'hAA});
    outq.push_back({1'b1, 8'h55});
    send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'hFD);
    repeat (3) @(posedge clk);
    evq.push_back(3);
    send(8'h77);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain(50);
    // 6: preamble garbage, SOF value as payload, then reset mid-payload
    evq.push_back(-1);
    outq.push_back({1'b1, 8'hA5});
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'hA5); send(8'hA4);
    wait_drain(50);
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("midreset_outs", {out_valid, out_data, out_last, frame_ok, frame_err, err_code, busy}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    evq.push_back(-1);
    outq.push_back({1'b1, 8'h3C});
    send(8'hA5); send(8'h01); send(8'h3C); send(8'h3D);
    wait_drain(50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
